// File: rtl/ir_pkg.sv
// Shared types and NEC timing constants for the IR receive path.
// Tokens carry one measured line segment from the front end to the frame decoder.
package ir_pkg;

  localparam int unsigned IR_WIDTH_BITS = 20;

  typedef enum logic [1:0] {
    StIdle,
    StMeasure,
    StStuck
  } ir_state_e;

  typedef struct packed {
    logic                     level;
    logic                     timeout;
    logic [IR_WIDTH_BITS-1:0] width;
  } ir_tok_t;

  // NEC segment durations in CLOCK_50 cycles.
  localparam int unsigned LEAD_LOW    = 450000;
  localparam int unsigned LEAD_HIGH   = 225000;
  localparam int unsigned BIT_LOW     = 28125;
  localparam int unsigned ZERO_HIGH   = 28125;
  localparam int unsigned ONE_HIGH    = 84375;
  localparam int unsigned REPEAT_HIGH = 112500;

endpackage

// File: rtl/ir_glitch_filter.sv
// Synchronises the raw IR line and debounces it; both edge polarities see the
// same latency, so filtered segment widths match the raw ones.
module ir_glitch_filter #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned GLITCH_CYCLES = 500
) (
  input  logic CLOCK_50,
  input  logic RESET,
  input  logic IRDA_RXD,
  output logic rx_level,
  output logic filt_edge
);

  localparam int unsigned CNT_W = $clog2(GLITCH_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GLITCH_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_bit;
  logic                   level_q, level_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   edge_q, edge_d;

  assign sync_bit = sync_q[SYNC_STAGES-1];

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    edge_d  = 1'b0;
    if (sync_bit != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
        edge_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      sync_q  <= '1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      edge_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], IRDA_RXD};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
    end
  end

  assign rx_level  = level_q;
  assign filt_edge = edge_q;

endmodule

// File: rtl/ir_rx_frontend.sv
// IR receive front end: filtered line -> segment width tokens -> small FIFO.
// The NEC decoder consumes tokens rather than sampling the pin.
module ir_rx_frontend
  import ir_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned GLITCH_CYCLES  = 500,
  parameter int unsigned WIDTH_BITS     = IR_WIDTH_BITS,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET,
  input  logic                  IRDA_RXD,
  output logic                  tok_valid,
  input  logic                  tok_ready,
  output logic                  tok_level,
  output logic [WIDTH_BITS-1:0] tok_width,
  output logic                  tok_timeout,
  output logic                  rx_level,
  output logic                  overflow
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [WIDTH_BITS-1:0] TIMEOUT_W = WIDTH_BITS'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic filt_edge;

  ir_glitch_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .GLITCH_CYCLES(GLITCH_CYCLES)
  ) u_filt (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .IRDA_RXD (IRDA_RXD),
    .rx_level (rx_level),
    .filt_edge(filt_edge)
  );

  ir_state_e             state_q, state_d;
  logic [WIDTH_BITS-1:0] wcnt_q, wcnt_d;
  logic                  push;
  ir_tok_t               push_tok;

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    push     = 1'b0;
    push_tok = '0;
    unique case (state_q)
      StIdle: begin
        wcnt_d = '0;
        if (filt_edge && !rx_level) begin
          state_d = StMeasure;
          wcnt_d  = WIDTH_BITS'(1);
        end
      end
      StMeasure: begin
        // An edge coinciding with the timeout wins: the segment ended in time.
        if (filt_edge) begin
          push           = 1'b1;
          push_tok.level = ~rx_level;
          push_tok.width = wcnt_q;
          wcnt_d         = WIDTH_BITS'(1);
        end else if (wcnt_q == TIMEOUT_W) begin
          push             = 1'b1;
          push_tok.level   = rx_level;
          push_tok.width   = TIMEOUT_W;
          push_tok.timeout = 1'b1;
          wcnt_d           = '0;
          state_d          = rx_level ? StIdle : StStuck;
        end else begin
          wcnt_d = wcnt_q + WIDTH_BITS'(1);
        end
      end
      StStuck: begin
        wcnt_d = '0;
        if (filt_edge && rx_level) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        wcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  ir_tok_t          mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic             pop, full, push_ok;
  ir_tok_t          head;

  assign full    = (count_q == DEPTH_C);
  assign pop     = tok_valid && tok_ready;
  // A pop frees the slot the same cycle, so a push into a full FIFO still lands.
  assign push_ok = push && (!full || pop);

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_tok;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (push_ok && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (!push_ok && pop) begin
        count_q <= count_q - CNT_W'(1);
      end
      if (push && full && !pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign head        = mem_q[rd_ptr_q];
  assign tok_valid   = (count_q != '0);
  assign tok_level   = head.level;
  assign tok_width   = head.width;
  assign tok_timeout = head.timeout;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_ir_rx_frontend.sv
// Scoreboard bench for ir_rx_frontend with time-scaled parameters; expected
// tokens come from constants or an event-level model of the filtered line.
module tb_ir_rx_frontend;
  import ir_pkg::*;

  localparam int unsigned S  = 2;
  localparam int unsigned G  = 20;
  localparam int unsigned T  = 3000;
  localparam int unsigned SC = 200;
  localparam int LL = LEAD_LOW / SC;
  localparam int LH = LEAD_HIGH / SC;
  localparam int BL = BIT_LOW / SC;
  localparam int ZH = ZERO_HIGH / SC;
  localparam int OH = ONE_HIGH / SC;
  localparam int RH = REPEAT_HIGH / SC;

  logic        CLOCK_50 = 1'b0;
  logic        RESET;
  logic        IRDA_RXD;
  logic        tok_valid;
  logic        tok_ready;
  logic        tok_level;
  logic [19:0] tok_width;
  logic        tok_timeout;
  logic        rx_level;
  logic        overflow;

  int      checks = 0;
  int      failures = 0;
  bit      rand_ready = 0;
  ir_tok_t exp_q[$];
  int      seg_l[$];
  int      seg_d[$];

  ir_rx_frontend #(
    .SYNC_STAGES   (S),
    .GLITCH_CYCLES (G),
    .WIDTH_BITS    (20),
    .TIMEOUT_CYCLES(T),
    .FIFO_DEPTH    (4)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .RESET      (RESET),
    .IRDA_RXD   (IRDA_RXD),
    .tok_valid  (tok_valid),
    .tok_ready  (tok_ready),
    .tok_level  (tok_level),
    .tok_width  (tok_width),
    .tok_timeout(tok_timeout),
    .rx_level   (rx_level),
    .overflow   (overflow)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic ir_tok_t mk(input bit l, input int w, input bit t);
    ir_tok_t r;
    r.level   = l;
    r.timeout = t;
    r.width   = IR_WIDTH_BITS'(w);
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted token is compared with the head of the scoreboard.
  always @(negedge CLOCK_50) begin
    if (!RESET && tok_valid === 1'b1 && tok_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_token actual={%0d,%0d,%0d} required=none",
                 tok_level, tok_width, tok_timeout);
      end else begin
        ir_tok_t e;
        e = exp_q.pop_front();
        if (tok_level !== e.level || tok_width !== e.width || tok_timeout !== e.timeout) begin
          failures++;
          $display("FAIL token actual={%0d,%0d,%0d} required={%0d,%0d,%0d}",
                   tok_level, tok_width, tok_timeout, e.level, e.width, e.timeout);
        end
      end
    end
  end

  task automatic drive(input logic lvl, input int dur);
    IRDA_RXD = lvl;
    for (int i = 0; i < dur; i++) begin
      @(posedge CLOCK_50);
      #1;
      if (rand_ready) tok_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    tok_ready = 1'b1;
    while (exp_q.size() != 0 && k < 500) begin
      @(posedge CLOCK_50);
      #1;
      k++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  // Event-level model: a raw segment differing from the filtered level for at
  // least G cycles moves the filtered edge to its start + G; tokens follow from
  // the gaps between filtered edges.
  task automatic model_push();
    int e_t[$];
    int e_l[$];
    int filt;
    int t;
    int st;  // 0 idle, 1 measuring, 2 stuck
    filt = 1;
    t = 0;
    st = 0;
    for (int i = 0; i < seg_l.size(); i++) begin
      if (seg_l[i] != filt && seg_d[i] >= int'(G)) begin
        e_t.push_back(t + int'(G));
        e_l.push_back(seg_l[i]);
        filt = seg_l[i];
      end
      t += seg_d[i];
    end
    for (int j = 0; j < e_t.size(); j++) begin
      int d;
      d = (j + 1 < e_t.size()) ? e_t[j+1] - e_t[j] : int'(T) + 1;
      if (st == 0 && e_l[j] == 0) st = 1;
      else if (st == 2 && e_l[j] == 1) st = 0;
      if (st == 1) begin
        if (d <= int'(T)) begin
          exp_q.push_back(mk(e_l[j][0], d, 1'b0));
        end else begin
          exp_q.push_back(mk(e_l[j][0], int'(T), 1'b1));
          st = (e_l[j] == 1) ? 0 : 2;
        end
      end
    end
  endtask

  task automatic run_seq();
    model_push();
    for (int i = 0; i < seg_l.size(); i++) drive(seg_l[i][0], seg_d[i]);
    seg_l.delete();
    seg_d.delete();
  endtask

  task automatic add(input int l, input int d);
    seg_l.push_back(l);
    seg_d.push_back(d);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESET = 1'b1;
    IRDA_RXD = 1'b1;
    tok_ready = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("rst_valid", int'(tok_valid), 0);
    chk("rst_rx_level", int'(rx_level), 1);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_level", int'(tok_level), 0);
    chk("rst_width", int'(tok_width), 0);
    chk("rst_timeout", int'(tok_timeout), 0);
    RESET = 1'b0;

    // Idle line: no tokens.
    tok_ready = 1'b1;
    drive(1'b1, 2 * T);
    chk("idle_valid", int'(tok_valid), 0);
    chk("idle_rx_level", int'(rx_level), 1);

    // Glitches: a G-1 pulse vanishes; 12 low / 3 high / 32 low gives one edge.
    drive(1'b0, G - 1);
    drive(1'b1, 200);
    chk("glitch_rx_level", int'(rx_level), 1);
    chk("glitch_valid", int'(tok_valid), 0);
    exp_q.push_back(mk(1'b0, 32, 1'b0));
    exp_q.push_back(mk(1'b1, T, 1'b1));
    drive(1'b0, 12);
    drive(1'b1, 3);
    drive(1'b0, 32);
    drive(1'b1, T + 100);
    wait_drain("glitch_drain");

    // NEC lead + one bit + final low, then the high timeout.
    exp_q.push_back(mk(1'b0, LL, 1'b0));
    exp_q.push_back(mk(1'b1, LH, 1'b0));
    exp_q.push_back(mk(1'b0, BL, 1'b0));
    exp_q.push_back(mk(1'b1, OH, 1'b0));
    exp_q.push_back(mk(1'b0, BL, 1'b0));
    exp_q.push_back(mk(1'b1, T, 1'b1));
    drive(1'b0, LL);
    drive(1'b1, LH);
    drive(1'b0, BL);
    drive(1'b1, OH);
    drive(1'b0, BL);
    drive(1'b1, T + 100);
    wait_drain("nec_drain");
    chk("nec_state_idle", int'(dut.state_q), int'(StIdle));

    // Stuck low: one timeout token, silent release, then a fresh measurement.
    exp_q.push_back(mk(1'b0, T, 1'b1));
    drive(1'b0, 3 * T);
    chk("stuck_state", int'(dut.state_q), int'(StStuck));
    drive(1'b1, 300);
    chk("stuck_release_state", int'(dut.state_q), int'(StIdle));
    chk("stuck_release_queue", exp_q.size(), 0);
    exp_q.push_back(mk(1'b0, 200, 1'b0));
    exp_q.push_back(mk(1'b1, T, 1'b1));
    drive(1'b0, 200);
    drive(1'b1, T + 100);
    wait_drain("stuck_drain");

    // Random segments, including lengths around G, with random backpressure.
    rand_ready = 1;
    for (int i = 0; i < 15; i++) begin
      add(i % 2, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, G + 2))
                                             : int'($urandom_range(G + 1, 400)));
    end
    add(1, T + 100);
    run_seq();
    rand_ready = 0;
    wait_drain("rand_drain");
    chk("rand_overflow", int'(overflow), 0);

    // Backpressure: four held, rest dropped, then a push+pop while full.
    tok_ready = 1'b0;
    exp_q.push_back(mk(1'b0, 100, 1'b0));
    exp_q.push_back(mk(1'b1, 110, 1'b0));
    exp_q.push_back(mk(1'b0, 120, 1'b0));
    exp_q.push_back(mk(1'b1, 130, 1'b0));
    drive(1'b0, 100);
    drive(1'b1, 110);
    drive(1'b0, 120);
    drive(1'b1, 130);
    drive(1'b0, 140);
    drive(1'b1, 150);
    chk("bp_overflow", int'(overflow), 1);
    chk("bp_count", int'(dut.count_q), 4);
    chk("bp_head_width", int'(tok_width), 100);
    exp_q.push_back(mk(1'b1, 150, 1'b0));
    exp_q.push_back(mk(1'b0, 160, 1'b0));
    exp_q.push_back(mk(1'b1, T, 1'b1));
    IRDA_RXD = 1'b0;
    repeat (S + G) begin
      @(posedge CLOCK_50);
      #1;
    end
    tok_ready = 1'b1;
    @(posedge CLOCK_50);
    #1;
    tok_ready = 1'b0;
    chk("bp_count_pushpop", int'(dut.count_q), 4);
    tok_ready = 1'b1;
    drive(1'b0, 160 - (S + G + 1));
    drive(1'b1, T + 100);
    wait_drain("bp_drain");
    chk("bp_overflow_sticky", int'(overflow), 1);

    // Reset in the middle of a lead low, then a full frame plus repeat burst.
    drive(1'b0, 1000);
    @(posedge CLOCK_50);
    #3;
    RESET = 1'b1;
    #1;
    chk("mid_rst_valid", int'(tok_valid), 0);
    chk("mid_rst_rx_level", int'(rx_level), 1);
    chk("mid_rst_overflow", int'(overflow), 0);
    chk("mid_rst_width", int'(tok_width), 0);
    chk("mid_rst_state", int'(dut.state_q), int'(StIdle));
    chk("mid_rst_queue", exp_q.size(), 0);
    IRDA_RXD = 1'b1;
    repeat (5) @(posedge CLOCK_50);
    #1;
    RESET = 1'b0;
    drive(1'b1, 50);
    add(0, LL); add(1, LH); add(0, BL); add(1, ZH); add(0, BL); add(1, OH);
    add(0, BL); add(1, RH); add(0, BL); add(1, T + 100);
    run_seq();
    wait_drain("frame_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ir_rx_frontend.md
Name: ir_rx_frontend

Overview:
- Conditions the raw IR receiver line (IRDA_RXD, idle high, active low) before NEC frame decoding.
- Synchronises the line, rejects glitches, and measures each low/high segment in CLOCK_50 cycles.
- Emits one {level, width, timeout} token per completed segment through a 4-entry valid/ready FIFO.
- The NEC frame decoder consumes these tokens instead of sampling the pin directly.

Parameters:
- SYNC_STAGES, 2, synchroniser flop count (>=2).
- GLITCH_CYCLES, 500, consecutive cycles (10 us) the synchronised line must differ from the filtered level before the filtered level toggles.
- WIDTH_BITS, 20, token width field size.
- TIMEOUT_CYCLES, 1000000, segment length (20 ms) that ends a burst; must be <= 2^WIDTH_BITS-1.
- FIFO_DEPTH, 4, token buffer entries (power of two).

Ports:
- CLOCK_50  in  1  50 MHz system clock
- RESET  in  1  asynchronous, active-high reset
- IRDA_RXD  in  1  raw IR receiver output, asynchronous, idle high
- tok_valid  out  1  FIFO head holds a token
- tok_ready  in  1  consumer accepts the head token this cycle
- tok_level  out  1  line level of the measured segment (0 = carrier burst)
- tok_width  out  WIDTH_BITS  segment duration in cycles
- tok_timeout  out  1  segment hit TIMEOUT_CYCLES; width equals TIMEOUT_CYCLES
- rx_level  out  1  filtered line level, for LED/debug
- overflow  out  1  sticky: a token was dropped because the FIFO was full

Behaviour:
- Reset values:
  - synchroniser flops = 1; rx_level = 1; filter counter = 0; width counter = 0.
  - state = IDLE; FIFO empty; tok_valid = 0; tok_level/tok_width/tok_timeout = 0; overflow = 0.
- Synchroniser: a SYNC_STAGES-flop chain. Latency is SYNC_STAGES cycles.
- Glitch filter:
  - When the synchronised bit differs from rx_level, the counter increments.
  - When the counter reaches GLITCH_CYCLES-1 and the bit still differs, rx_level toggles that cycle and the counter clears.
  - Any cycle where the bit equals rx_level clears the counter.
  - Pulses shorter than GLITCH_CYCLES are invisible.
  - Edge latency is SYNC_STAGES+GLITCH_CYCLES cycles, identical for both polarities, so segment widths are preserved exactly.
- filt_edge is a one-cycle strobe when rx_level toggles.
- State machine (IDLE, MEASURE, STUCK):
  - IDLE: width counter held at 0; no tokens. A falling filt_edge moves to MEASURE with width counter = 1.
  - MEASURE: the width counter increments each cycle.
    - On filt_edge: push {previous level, counter, 0}; counter = 1; stay in MEASURE.
    - If the counter reaches TIMEOUT_CYCLES with no edge and level high: push {1, TIMEOUT_CYCLES, 1}; go to IDLE.
    - If the counter reaches TIMEOUT_CYCLES with no edge and level low: push {0, TIMEOUT_CYCLES, 1}; go to STUCK.
    - An edge on the same cycle as the timeout counts as an edge: push the normal token, no timeout.
  - STUCK: no tokens. A rising filt_edge goes to IDLE.
- Width arithmetic: unsigned, never exceeds TIMEOUT_CYCLES, no wrap.
- FIFO:
  - Push occurs on the token event; pop occurs when tok_valid && tok_ready.
  - Head outputs are registered and valid when tok_valid = 1.
  - A push when full with no pop in the same cycle drops the new token and sets overflow.
  - A push and pop in the same cycle while full are both accepted; occupancy is unchanged.
  - A push and pop in the same cycle while empty: the pop is ignored (tok_valid was 0) and the push lands.
  - overflow clears only on RESET.
- Reset mid-operation: all state is cleared immediately (asynchronously). A frame in progress is discarded and no partial token is emitted.

Decomposition:
- Package ir_pkg:
  - state enum {IDLE, MEASURE, STUCK}.
  - packed struct ir_tok_t {level, timeout, width[WIDTH_BITS-1:0]}.
  - NEC timing constants in CLOCK_50 cycles: LEAD_LOW 450000, LEAD_HIGH 225000, BIT_LOW 28125, ZERO_HIGH 28125, ONE_HIGH 84375, REPEAT_HIGH 112500.
- Sub-module ir_glitch_filter contains the synchroniser and debounce counter; it outputs rx_level and filt_edge.
- The FIFO stays inline in the top module.

Test Plan:
- Reset, IRDA_RXD held high for 2,000,000 cycles -> tok_valid stays 0, rx_level = 1.
- NEC lead (low 450000, high 225000), then one bit (low 28125, high 84375), then a final low 28125, tok_ready = 1:
  - tokens {0,450000,0}, {1,225000,0}, {0,28125,0}, {1,84375,0}, {0,28125,0}, then {1,1000000,1};
  - the FSM then returns to IDLE.
- Glitch rejection:
  - a 499-cycle low pulse on an idle line -> no edge, no tokens;
  - a low of 300 cycles, high of 5, low of 800, the low counted from its last falling edge (net 800 >= 500) -> exactly one falling edge.
- Stuck low (line held low for 3,000,000 cycles, then released) -> exactly one token {0,1000000,1}; no token on release; the next falling edge restarts MEASURE.
- Backpressure: tok_ready = 0, six segment edges -> 4 tokens held, overflow = 1, first four tokens intact and in order; push and pop in the same cycle while full keeps occupancy 4.
- Assert RESET mid-lead (cycle 200000 of the low) -> all outputs return to reset values that cycle; after release, a full frame decodes with correct widths.
